// File: rtl/wb_daq_sram_writer.sv
// wb_daq_sram_writer
// Round-robin arbiter that drains per-channel DAQ words into per-channel
// circular SRAM regions, one Wishbone classic write per grant. Each granted
// channel receives a single-cycle data_done once its word has been written
// (or dropped on a bus error).

module wb_daq_sram_writer #(
  parameter int dw            = 32,
  parameter int aw            = 32,
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WORDS = 256
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic                       enable,
  input  logic [aw-1:0]              base_address,
  input  logic [NUM_CHANNELS-1:0]    start_sram,
  input  logic [NUM_CHANNELS*dw-1:0] channel_data,
  input  logic                       clear_flags,
  output logic [NUM_CHANNELS-1:0]    data_done,
  output logic [aw-1:0]              wb_adr_o,
  output logic [dw-1:0]              wb_dat_o,
  output logic [dw/8-1:0]            wb_sel_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  output logic [NUM_CHANNELS-1:0]    wrapped,
  output logic                       bus_error,
  output logic                       busy
);

  // Grant index width; a single-channel build still needs a 1-bit index.
  localparam int gw = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  // Ring pointer width; CHANNEL_WORDS is a power of two so the pointer
  // wraps naturally when it overflows.
  localparam int pw = $clog2(CHANNEL_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [gw-1:0]   rr_ptr;
  logic [gw-1:0]   grant;
  logic [pw-1:0]   ptr [NUM_CHANNELS];

  logic [dw-1:0]   chan_word [NUM_CHANNELS];
  logic            pick_valid;
  logic [gw-1:0]   pick_idx;
  logic [aw-1:0]   word_off;
  logic [aw-1:0]   pick_adr;

  // Unpack the flat channel bus into one word per channel.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      chan_word[i] = channel_data[i*dw +: dw];
    end
  end

  // Round-robin pick: first requesting channel at or after rr_ptr, with wrap.
  // Offsets are scanned from the farthest down to the nearest so that the
  // closest requester is the last (winning) assignment. rr_ptr + k is below
  // 2*NUM_CHANNELS, so matching j or j+NUM_CHANNELS covers the wrap without
  // a modulo.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_CHANNELS; j++) begin
        if (start_sram[j] &&
            ((int'(rr_ptr) + k == j) || (int'(rr_ptr) + k == j + NUM_CHANNELS))) begin
          pick_valid = 1'b1;
          pick_idx   = gw'(j);
        end
      end
    end
  end

  // Byte address of the picked channel's next ring slot.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see
    // the updated value; clocked state uses '<=' so all registers update
    // together from the values held before the edge.
    word_off = aw'(pick_idx) * aw'(CHANNEL_WORDS) + aw'(ptr[pick_idx]);
    pick_adr = base_address + (word_off << 2);
  end

  // Transfer FSM with registered Wishbone outputs, pointers and sticky flags.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      // NOTE: the ring pointers are architectural state (they define where
      // the next word lands), so this small register array is reset; a true
      // data-storage RAM would be left unreset.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ptr[i] <= '0;
      end
      data_done <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wrapped   <= '0;
      bus_error <= 1'b0;
    end else begin
      // Clear first; a set later in this block overrides it in the same cycle.
      if (clear_flags) begin
        wrapped   <= '0;
        bus_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable && pick_valid) begin
            grant    <= pick_idx;
            wb_adr_o <= pick_adr;
            wb_dat_o <= chan_word[pick_idx];
            wb_sel_o <= '1;
            wb_we_o  <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= WRITE;
          end
        end

        WRITE: begin
          // An error (alone or together with ack) drops the word; the
          // channel is still released so it never stalls on a bad slave.
          if (wb_ack_i || wb_err_i) begin
            wb_we_o          <= 1'b0;
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
            data_done[grant] <= 1'b1;
            if (wb_err_i) begin
              bus_error <= 1'b1;
            end
            state <= DONE;
          end
        end

        DONE: begin
          data_done  <= '0;
          ptr[grant] <= ptr[grant] + pw'(1);
          if (ptr[grant] == '1) begin
            wrapped[grant] <= 1'b1;
          end
          rr_ptr <= (grant == gw'(NUM_CHANNELS - 1)) ? '0 : grant + gw'(1);
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/wb_daq_sram_writer.md
# wb_daq_sram_writer

Multi-channel SRAM write arbiter that sits directly downstream of the per-channel DAQ data paths. It accepts each channel's `start_sram`/`data_out` request and grants channels round-robin. For each granted word it performs one Wishbone classic write to a per-channel circular SRAM region, then returns a one-cycle `data_done` to that channel. Each channel therefore drains its FIFO one 32-bit word per grant into its own ring buffer.

## Interface
Parameters:
- `dw`, 32: data width of channel words and Wishbone data bus.
- `aw`, 32: Wishbone byte-address width.
- `NUM_CHANNELS`, 4: number of requesting channels (≥1).
- `CHANNEL_WORDS`, 256: words per channel ring region (power of two, ≥2).

Ports:
- `wb_clk` in 1: single clock for the whole block.
- `wb_rst` in 1: reset, synchronous and active-high.
- `enable` in 1: global enable; gates new grants only.
- `base_address` in aw: byte address of channel 0 region; word aligned.
- `start_sram` in NUM_CHANNELS: per-channel write request (level).
- `channel_data` in NUM_CHANNELS*dw: channel i's word in bits [i*dw +: dw].
- `clear_flags` in 1: clears the sticky `wrapped` and `bus_error` flags.
- `data_done` out NUM_CHANNELS: one-cycle pulse to the granted channel after its word is written.
- `wb_adr_o` out aw, `wb_dat_o` out dw, `wb_sel_o` out dw/8, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1: Wishbone master.
- `wb_ack_i` in 1, `wb_err_i` in 1: Wishbone slave responses.
- `wrapped` out NUM_CHANNELS: sticky; set when channel i's pointer wraps to 0.
- `bus_error` out 1: sticky; set on `wb_err_i`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, WRITE and DONE.
- **IDLE:**
  - If `enable` is high and any `start_sram` bit is set, select the first requesting channel at or after `rr_ptr`, searching upward with wrap.
  - Register the grant index, `wb_adr_o`, and `wb_dat_o` taken from that channel's slice.
  - Go to WRITE. In the same edge, assert `wb_cyc_o`, `wb_stb_o` and `wb_we_o`, with `wb_sel_o` all ones.
- **WRITE:**
  - Hold all bus outputs stable until `wb_ack_i` or `wb_err_i` is sampled high.
  - On that edge, deassert `wb_cyc_o`, `wb_stb_o` and `wb_we_o`, and go to DONE.
  - On `wb_err_i`, set `bus_error`. The word is dropped, not retried.
- **DONE:**
  - Assert `data_done[grant]` for exactly this cycle.
  - Set `ptr[grant] <= ptr[grant]+1` modulo CHANNEL_WORDS. On the transition CHANNEL_WORDS-1 → 0, set `wrapped[grant]`.
  - Set `rr_ptr <= grant+1` modulo NUM_CHANNELS.
  - Go to IDLE.
- **Address:** `wb_adr_o = base_address + ((grant*CHANNEL_WORDS + ptr[grant]) << 2)`, truncated to aw bits.
- **Channel contract:** a channel must reflect its response to `data_done` (pop, or deassert `start_sram`) by the following cycle. IDLE samples `start_sram` no earlier than that cycle.
- **`enable` low:** no new grant is issued. An in-flight write completes normally, including its DONE pulse.
- **`clear_flags`:** zeroes `wrapped` and `bus_error` in any state. If a set event occurs in the same cycle, the set wins.
- **Both `wb_ack_i` and `wb_err_i` high:** treated as an error (flag set, word dropped).

## Timing
- Reset values:
  - State IDLE; `rr_ptr` 0; all `ptr` 0.
  - `data_done`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `busy`, `wrapped`, `bus_error` all 0.
  - `wb_adr_o`, `wb_dat_o`, `wb_sel_o` all 0.
- Request sampled in IDLE at edge N → `wb_stb_o` high in cycle N+1.
- `wb_ack_i` sampled at edge M → `data_done` high in cycle M+1 → IDLE in cycle M+2.
- Minimum throughput is 3 cycles per word, with zero-wait ack.
- Reset asserted mid-transaction: all outputs return to reset values after the next edge, with no `data_done` issued.

## Test plan
- **Single channel:** NUM_CHANNELS=4, CHANNEL_WORDS=4, base 0x1000. Channel 2 requests with data 0xA5A5_0001 and immediate ack → write to 0x1020 with that data, one `data_done[2]` pulse, next address 0x1024.
- **Round-robin fairness:** all four channels request continuously, 5 grants → grant order 0,1,2,3,0; addresses 0x1000, 0x1010, 0x1020, 0x1030, 0x1004.
- **Wrap-around:** channel 1 writes 5 words → addresses 0x1010, 0x1014, 0x1018, 0x101C, 0x1010; `wrapped[1]` sets on the 4th DONE; `clear_flags` then clears it.
- **Wait states and error:** ack delayed 3 cycles → bus outputs stable throughout, `data_done` exactly 1 cycle after ack. `wb_err_i` instead of ack → `bus_error`=1, `data_done` pulses, pointer advances.
- **Enable and reset:** `enable` dropped during WRITE → transfer completes, no further `wb_stb_o`. `wb_rst` during WRITE → `wb_cyc_o`=0 after the next edge, pointers 0, no `data_done`.
